// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, key-event layout and frame FSM state names.
// Also hosts the 11-bit frame builder: start 0, data LSB first, odd parity, stop 1.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam int         PS2_FRAME_BITS   = 11;

  typedef struct packed {
    logic       toggle;
    logic       press;
    logic       ext;
    logic [7:0] code;
  } ps2_key_event_t;

  typedef enum logic [2:0] {
    PS2_IDLE,
    PS2_HIGH,
    PS2_LOW,
    PS2_GAP,
    PS2_INHIBIT
  } ps2_state_e;

  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_dev_serializer.sv
// PS/2 device-side serializer: one byte per frame, then GAP_BITS idle bit periods.
// With PS2_INHIBIT_EN the host can hold ps2_clk_in low to block or abort; the held byte is resent.
module ps2_dev_serializer
  import ps2_pkg::*;
#(
  parameter int HALF     = 50,
  parameter int GAP_BITS = 2
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [7:0] byte_i,
  input  logic       byte_vld_i,
  output logic       byte_rdy_o,
`ifdef PS2_INHIBIT_EN
  input  logic       ps2_clk_in,
`endif
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       active_o
);

  localparam int GAP_CYC = GAP_BITS * 2 * HALF;
  localparam int CNT_MAX = (GAP_CYC > HALF) ? GAP_CYC : HALF;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [3:0]                idx_q, idx_d;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic                      can_start;
  logic                      abort;

`ifdef PS2_INHIBIT_EN
  logic clk_in_low_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) clk_in_low_q <= 1'b0;
    else        clk_in_low_q <= ~ps2_clk_in;
  end

  assign can_start = ps2_clk_in;
  // Two consecutive low samples filter a single-cycle glitch on the host clock.
  assign abort     = (idx_q < LAST_BIT) && ~ps2_clk_in && clk_in_low_q;
`else
  assign can_start = 1'b1;
  assign abort     = 1'b0;
`endif

  assign byte_rdy_o = (state_q == PS2_IDLE) && can_start;
  assign active_o   = (state_q != PS2_IDLE);
  assign ps2_clk    = (state_q != PS2_LOW);
  assign ps2_data   = (state_q == PS2_HIGH || state_q == PS2_LOW) ? frame_q[idx_q] : 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    frame_d = frame_q;
    case (state_q)
      PS2_IDLE: begin
        cnt_d = '0;
        if (byte_vld_i && can_start) begin
          frame_d = ps2_frame(byte_i);
          idx_d   = '0;
          state_d = PS2_HIGH;
        end
      end
      PS2_HIGH: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = PS2_INHIBIT;
        end else if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = PS2_LOW;
        end
      end
      PS2_LOW: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (idx_q == LAST_BIT) begin
            state_d = PS2_GAP;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = PS2_HIGH;
          end
        end
      end
      PS2_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = PS2_IDLE;
        end
      end
      PS2_INHIBIT: begin
        cnt_d = '0;
        if (can_start) begin
          idx_d   = '0;
          state_d = PS2_HIGH;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = PS2_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PS2_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: rtl/ps2_key_tx.sv
// Key events -> scan-code set 2 bytes (E0, F0, code) -> byte FIFO -> PS/2 device serializer.
// Optional PS2_INHIBIT_EN adds the ps2_clk_in host-inhibit sense input.
module ps2_key_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int PS2_HZ     = 12000,
  parameter int GAP_BITS   = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [10:0] ps2_key,
`ifdef PS2_INHIBIT_EN
  input  logic        ps2_clk_in,
`endif
  output logic        ps2_clk,
  output logic        ps2_data,
  output logic        busy,
  output logic        overflow
);

  localparam int HALF = CLK_HZ / (2 * PS2_HZ);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  ps2_key_event_t key_ev;
  logic           armed_q, prev_tog_q;
  logic           ev_vld_q, ev_press_q, ev_ext_q;
  logic [7:0]     ev_code_q;

  assign key_ev = ps2_key;

  // First cycle out of reset only samples the toggle so a stale level is not an event.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      armed_q    <= 1'b0;
      prev_tog_q <= 1'b0;
      ev_vld_q   <= 1'b0;
      ev_press_q <= 1'b0;
      ev_ext_q   <= 1'b0;
      ev_code_q  <= '0;
    end else begin
      armed_q    <= 1'b1;
      ev_vld_q   <= armed_q && (key_ev.toggle != prev_tog_q);
      ev_press_q <= key_ev.press;
      ev_ext_q   <= key_ev.ext;
      ev_code_q  <= key_ev.code;
      if (!armed_q || key_ev.toggle != prev_tog_q) prev_tog_q <= key_ev.toggle;
    end
  end

  logic [2:0][7:0] seq;
  logic [1:0]      n_bytes;

  always_comb begin
    seq     = {ev_code_q, ev_code_q, ev_code_q};
    n_bytes = 2'd1;
    case ({ev_ext_q, ev_press_q})
      2'b11: begin
        seq[0]  = PS2_EXT_PREFIX;
        n_bytes = 2'd2;
      end
      2'b10: begin
        seq[0]  = PS2_EXT_PREFIX;
        seq[1]  = PS2_BREAK_PREFIX;
        n_bytes = 2'd3;
      end
      2'b00: begin
        seq[0]  = PS2_BREAK_PREFIX;
        n_bytes = 2'd2;
      end
      default: ;
    endcase
  end

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]        used, free;
  logic [2:0][AW-1:0] waddr;
  logic               push, fifo_vld, fifo_pop, ser_rdy, ser_active;

  // Free space is taken before this cycle's pop, so a whole event fits or none of it does.
  assign used     = wr_ptr_q - rd_ptr_q;
  assign free     = DEPTH - used;
  assign push     = ev_vld_q && (free >= (AW+1)'(n_bytes));
  assign overflow = ev_vld_q && !push;
  assign fifo_vld = (used != '0);
  assign fifo_pop = fifo_vld && ser_rdy;
  assign busy     = fifo_vld || ser_active;

  always_comb begin
    for (int i = 0; i < 3; i++) waddr[i] = wr_ptr_q[AW-1:0] + AW'(i);
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      for (int i = 0; i < 3; i++) begin
        if (i < int'(n_bytes)) mem_q[waddr[i]] <= seq[i];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push)     wr_ptr_q <= wr_ptr_q + (AW+1)'(n_bytes);
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  ps2_dev_serializer #(
    .HALF     (HALF),
    .GAP_BITS (GAP_BITS)
  ) u_ser (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .byte_i     (mem_q[rd_ptr_q[AW-1:0]]),
    .byte_vld_i (fifo_vld),
    .byte_rdy_o (ser_rdy),
`ifdef PS2_INHIBIT_EN
    .ps2_clk_in (ps2_clk_in),
`endif
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .active_o   (ser_active)
  );

endmodule

// File: doc/ps2_key_tx.md
Name: ps2_key_tx

Overview:
- Device-side PS/2 keyboard transmitter. It is the other end of the PS/2 link that the console's keyboard receiver decodes.
- Converts MiSTer-style 11-bit key events ({toggle, press, extended, code}) into scan-code set 2 byte sequences and serialises them as open-drain-style PS/2 clock/data frames.
- Sits between hps_io key output and the FpgaVirtualConsole `ps2` input. It replaces the canned PS/2 bitstream with one the team controls and can rate-limit.

Parameters:
- CLK_HZ, 100000000, clk_sys frequency in Hz.
- PS2_HZ, 12000, PS/2 clock frequency; HALF = CLK_HZ/(2*PS2_HZ) cycles per clock phase.
- GAP_BITS, 2, idle bit periods (clk high, data high) inserted between bytes.
- FIFO_DEPTH, 16, byte FIFO entries; must be a power of two and at least 4.

Ports:
- clk_sys  in  1  system clock; every register is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ps2_key  in  11  [10] toggle, [9] press, [8] extended, [7:0] code.
- ps2_clk  out  1  PS/2 clock to receiver; idle high.
- ps2_data  out  1  PS/2 data to receiver; idle high.
- busy  out  1  high while the FIFO is non-empty or a frame/gap is in progress.
- overflow  out  1  one-cycle pulse when an event is dropped.
- ps2_clk_in  in  1  host clock sense; present only with PS2_INHIBIT_EN.

Behaviour:
- Reset: ps2_clk=1, ps2_data=1, busy=0, overflow=0, FIFO empty, FSM=IDLE, armed=0, prev_toggle=0.
- Arming: the first cycle after reset release sets armed=1 and loads prev_toggle from ps2_key[10]; no event is generated.
- Event detection: when armed and ps2_key[10] != prev_toggle, an event occurs and prev_toggle updates. Required bytes:
  - extended: E0.
  - release (press=0): F0.
  - always: code.
  - N = 1..3 bytes total.
- Enqueue: bytes are pushed atomically in the cycle after detection, in the order E0, F0, code.
  - If free entries < N, no bytes are pushed and overflow pulses for 1 cycle.
  - Enqueue in the same cycle as a dequeue is legal; free count is evaluated before that cycle's pop.
- Frame: 11 bits — start 0, data[0..7] LSB first, odd parity, stop 1.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop a byte into the shift register and go to HIGH with bit index 0.
  - HIGH: ps2_clk=1; ps2_data = current bit, driven from the first cycle of HIGH. After HALF cycles, go to LOW.
  - LOW: ps2_clk=0 (receiver samples on the falling edge). After HALF cycles: if bit index = 10, go to GAP; else increment the index and go to HIGH.
  - GAP: ps2_clk=1, ps2_data=1 for GAP_BITS*2*HALF cycles, then IDLE.
- Latency: a single event with an empty FIFO gives the first ps2_clk falling edge 2+1+HALF cycles after the toggle changes.
- Frame timing: one byte occupies 22*HALF + GAP_BITS*2*HALF cycles.
- busy: combinational OR of FIFO non-empty and state != IDLE.
- Phase counter: counts 0..HALF-1 and restarts on every state entry.
- Wrap: FIFO pointers wrap modulo FIFO_DEPTH; an extra bit distinguishes full from empty.
- Reset mid-frame: lines return high immediately (asynchronously); the partial byte and all queued bytes are discarded.

Optional Feature:
- PS2_INHIBIT_EN defined:
  - Adds the ps2_clk_in port.
  - In IDLE, a pop is blocked while ps2_clk_in=0.
  - In HIGH with bit index < 10, if ps2_clk_in=0 for 2 consecutive cycles, the frame is aborted: lines go high and the FSM returns to an INHIBIT state.
  - INHIBIT waits for ps2_clk_in=1, then retransmits the same byte from the start bit (the byte is held, not re-popped).
- PS2_INHIBIT_EN undefined: ps2_clk_in does not exist and frames always complete.

Decomposition:
- Package ps2_pkg:
  - constants PS2_EXT_PREFIX=8'hE0, PS2_BREAK_PREFIX=8'hF0, PS2_FRAME_BITS=11.
  - typedef struct packed ps2_key_event_t {toggle, press, ext, code[7:0]}.
  - typedef enum PS2_IDLE, PS2_HIGH, PS2_LOW, PS2_GAP, PS2_INHIBIT.
- Sub-module ps2_dev_serializer:
  - contains the frame FSM and timing counters.
  - interface: byte in, valid/ready handshake, ps2_clk, ps2_data.
- Top level holds event detection, byte sequencing and the FIFO.

Test Plan (CLK_HZ=1200000, PS2_HZ=12000, so HALF=50; GAP_BITS=2):
- Make 0x1C (toggle 0->1, press=1, ext=0) -> one frame. Bits sampled at ps2_clk falls are 0, 0,0,1,1,1,0,0,0, parity 0, stop 1. First falling edge 53 cycles after the toggle; busy deasserts 1300 cycles after the first pop.
- Release of extended 0x74 -> three frames, E0 then F0 then 74. Parity bits 0, 1, 1. Gap between frames is 200 cycles of both lines high.
- Toggle held static through reset release and 10 cycles -> no frames, overflow stays 0 (arming).
- FIFO_DEPTH=4: three extended releases back-to-back, 2 cycles apart -> first event queued; second and third each pulse overflow once; exactly 3 bytes transmitted.
- Assert rst_n=0 during bit 4 of a frame -> ps2_clk and ps2_data are 1 in the same cycle; after release, no residual frames are sent.
- With PS2_INHIBIT_EN: pull ps2_clk_in low during the HIGH phase of bit 3 for 100 cycles -> abort; after release, the full byte is retransmitted from the start bit.
